output_vc_switch_allocator: RTL and testbench

- Per-output-port scheduler placed in front of the output block.
- Arbitrates between the router's input ports competing for this output, and enforces wormhole ownership of each downstream VC.
- Checks per-VC credit availability, including the grant still in flight from the previous cycle.
- Drives the output block's registered enable and the crossbar select.

---
 rtl/output_vc_switch_allocator.sv | 226 ++++++++++++++++++++++
 tb/tb_output_vc_switch_allocator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_vc_switch_allocator.sv
// -----------------------------------------------------------------------------
// output_vc_switch_allocator
//
// Per-output-port scheduler sitting in front of the output block. It picks at
// most one of the router's input ports each cycle (round-robin), enforces
// wormhole ownership of every downstream VC, and only grants when the target
// VC has a credit left. A credit is treated as already spent while the grant
// issued on the previous edge is still travelling to the output block.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   req_i[NUM_IN]               input i has a flit at its head for this output
//   req_ftype_i[NUM_IN]         flit type of that head flit (I/H/B/T)
//   req_vc_i[NUM_IN]            downstream VC of that head flit
//   credits_avail_count_r_i     per-VC credit counts from the output block
//   gnt_r_o[NUM_IN]             registered one-hot grant (granted input pops)
//   ob_en_r_o                   registered output block enable (= |gnt_r_o)
//   sel_r_o                     registered crossbar select (granted input)
//   vc_busy_r_o[NUM_VCS]        VC owned by a packet in progress
//   vc_owner_r_o[NUM_VCS]       owning input of each VC
//
// Flit type encoding: 0 = I (idle), 1 = H (head), 2 = B (body), 3 = T (tail).
// -----------------------------------------------------------------------------

// Eligibility of one input port for the current cycle.
module output_vc_switch_allocator_elig #(
    parameter int                  NUM_VCS  = 4,
    parameter int                  VC_BITS  = 2,
    parameter int                  SEL_BITS = 3,
    parameter logic [SEL_BITS-1:0] IDX      = '0
) (
    input  logic                              req_i,
    input  logic [1:0]                        ftype_i,
    input  logic [VC_BITS-1:0]                vc_i,
    input  logic                              popping_i,
    input  logic [NUM_VCS-1:0]                credit_ok_i,
    input  logic [NUM_VCS-1:0]                vc_busy_i,
    input  logic [NUM_VCS-1:0][SEL_BITS-1:0]  vc_owner_i,
    output logic                              elig_o
);
    localparam logic [1:0] FT_H = 2'd1;
    localparam logic [1:0] FT_B = 2'd2;
    localparam logic [1:0] FT_T = 2'd3;

    always_comb begin
        elig_o = 1'b0;
        // popping_i: this input was granted last edge and is still popping
        if (req_i && !popping_i && credit_ok_i[vc_i]) begin
            case (ftype_i)
                FT_H:       elig_o = !vc_busy_i[vc_i];
                FT_B, FT_T: elig_o = vc_busy_i[vc_i] && (vc_owner_i[vc_i] == IDX);
                default:    elig_o = 1'b0;
            endcase
        end
    end
endmodule

module output_vc_switch_allocator #(
    parameter int    NUM_IN           = 5,
    parameter int    NUM_VCS          = 4,
    parameter int    VC_BITS          = $clog2(NUM_VCS),
    parameter int    SEL_BITS         = $clog2(NUM_IN),
    parameter int    CREDIT_CTR_WIDTH = 4,
    parameter string LOCAL_PORT       = "W"
) (
    input  logic                                        clk,
    input  logic                                        arst_n,
    input  logic [NUM_IN-1:0]                           req_i,
    input  logic [NUM_IN-1:0][1:0]                      req_ftype_i,
    input  logic [NUM_IN-1:0][VC_BITS-1:0]              req_vc_i,
    input  logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]    credits_avail_count_r_i,
    output logic [NUM_IN-1:0]                           gnt_r_o,
    output logic                                        ob_en_r_o,
    output logic [SEL_BITS-1:0]                         sel_r_o,
    output logic [NUM_VCS-1:0]                          vc_busy_r_o,
    output logic [NUM_VCS-1:0][SEL_BITS-1:0]            vc_owner_r_o
);
    localparam logic [1:0] FT_H = 2'd1;
    localparam logic [1:0] FT_B = 2'd2;
    localparam logic [1:0] FT_T = 2'd3;

    logic [NUM_IN-1:0]                gnt_q, gnt_d;
    logic                             ob_en_q, ob_en_d;
    logic [SEL_BITS-1:0]              sel_q, sel_d;
    logic [SEL_BITS-1:0]              rr_q, rr_d;
    logic [VC_BITS-1:0]               pend_vc_q, pend_vc_d;
    logic [NUM_VCS-1:0]               busy_q, busy_d;
    logic [NUM_VCS-1:0][SEL_BITS-1:0] owner_q, owner_d;

    logic [NUM_VCS-1:0]               credit_ok;
    logic [NUM_IN-1:0]                elig;
    logic                             found;
    logic [SEL_BITS-1:0]              win;
    logic [VC_BITS-1:0]               win_vc;
    logic [1:0]                       win_ft;

    // The output block only decrements one cycle after ob_en, so the VC of
    // the grant in flight has one credit fewer than its counter shows.
    always_comb begin
        credit_ok = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_ok[v] = credits_avail_count_r_i[v] >
                           CREDIT_CTR_WIDTH'(ob_en_q && (pend_vc_q == VC_BITS'(v)));
        end
    end

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
        output_vc_switch_allocator_elig #(
            .NUM_VCS  (NUM_VCS),
            .VC_BITS  (VC_BITS),
            .SEL_BITS (SEL_BITS),
            .IDX      (SEL_BITS'(gi))
        ) u_elig (
            .req_i       (req_i[gi]),
            .ftype_i     (req_ftype_i[gi]),
            .vc_i        (req_vc_i[gi]),
            .popping_i   (gnt_q[gi]),
            .credit_ok_i (credit_ok),
            .vc_busy_i   (busy_q),
            .vc_owner_i  (owner_q),
            .elig_o      (elig[gi])
        );
    end

    // Round-robin search starting at rr_q, wrapping NUM_IN-1 -> 0.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = SEL_BITS'(idx);
            end
        end
    end

    assign win_vc = req_vc_i[win];
    assign win_ft = req_ftype_i[win];

    always_comb begin
        gnt_d     = '0;
        ob_en_d   = 1'b0;
        sel_d     = sel_q;
        rr_d      = rr_q;
        pend_vc_d = pend_vc_q;
        busy_d    = busy_q;
        owner_d   = owner_q;
        if (found) begin
            gnt_d[win] = 1'b1;
            ob_en_d    = 1'b1;
            sel_d      = win;
            pend_vc_d  = win_vc;
            rr_d       = (win == SEL_BITS'(NUM_IN - 1)) ? '0 : win + SEL_BITS'(1);
            if (win_ft == FT_H) begin
                busy_d[win_vc]  = 1'b1;
                owner_d[win_vc] = win;
            end else if (win_ft == FT_T) begin
                // owner is left stale; busy alone decides availability
                busy_d[win_vc] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            gnt_q     <= '0;
            ob_en_q   <= 1'b0;
            sel_q     <= '0;
            rr_q      <= '0;
            pend_vc_q <= '0;
            busy_q    <= '0;
            owner_q   <= '0;
        end else begin
            gnt_q     <= gnt_d;
            ob_en_q   <= ob_en_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            pend_vc_q <= pend_vc_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
        end
    end

    assign gnt_r_o      = gnt_q;
    assign ob_en_r_o    = ob_en_q;
    assign sel_r_o      = sel_q;
    assign vc_busy_r_o  = busy_q;
    assign vc_owner_r_o = owner_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (arst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                // The head of a popping input is the flit already granted
                // (a tail may have just released its VC), so skip it.
                if (req_i[i] && !gnt_q[i] &&
                    (req_ftype_i[i] == FT_B || req_ftype_i[i] == FT_T) &&
                    !(busy_q[req_vc_i[i]] && owner_q[req_vc_i[i]] == SEL_BITS'(i)))
                    $error("[%s] input %0d: B/T flit on VC %0d it does not own",
                           LOCAL_PORT, i, req_vc_i[i]);
            end
            if (!$onehot0(gnt_q))
                $error("[%s] gnt_r not one-hot: %b", LOCAL_PORT, gnt_q);
            if (ob_en_q != |gnt_q)
                $error("[%s] ob_en_r disagrees with gnt_r", LOCAL_PORT);
        end
    end

    // The VC id can only exceed NUM_VCS when NUM_VCS is not a power of two.
    if ((1 << VC_BITS) != NUM_VCS) begin : g_vc_range
        always @(posedge clk) begin
            if (arst_n) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (req_i[i] && (int'(req_vc_i[i]) >= NUM_VCS))
                        $error("[%s] input %0d: VC %0d out of range",
                               LOCAL_PORT, i, req_vc_i[i]);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_output_vc_switch_allocator.sv
module tb_output_vc_switch_allocator;
    localparam int NI = 5, NV = 4, VB = 2, SB = 3, CW = 4;
    localparam int FT_I = 0, FT_H = 1, FT_B = 2, FT_T = 3;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    logic [NI-1:0]          req = '0;
    logic [NI-1:0][1:0]     req_ft = '0;
    logic [NI-1:0][VB-1:0]  req_vc = '0;
    logic [NV-1:0][CW-1:0]  cred = '0;
    logic [NI-1:0]          gnt;
    logic                   ob_en;
    logic [SB-1:0]          sel;
    logic [NV-1:0]          busy;
    logic [NV-1:0][SB-1:0]  owner;

    always #5 clk = ~clk;

    output_vc_switch_allocator #(
        .NUM_IN(NI), .NUM_VCS(NV), .CREDIT_CTR_WIDTH(CW), .LOCAL_PORT("W")
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .req_i(req), .req_ftype_i(req_ft), .req_vc_i(req_vc),
        .credits_avail_count_r_i(cred),
        .gnt_r_o(gnt), .ob_en_r_o(ob_en), .sel_r_o(sel),
        .vc_busy_r_o(busy), .vc_owner_r_o(owner)
    );

    int total = 0, bad = 0;
    bit chk_en = 0;

    // Per-input flit queues, flit = ftype*16 + vc
    int fq [NI][$];
    // Reference model state
    int m_win = -1, m_sel = 0, m_rr = 0, m_pend = 0;
    bit m_busy [NV];
    int m_owner [NV];
    // Output-block credit counter and credits held downstream
    int cnt [NV];
    int used [NV];
    bit gen_en = 0;
    int p_req = 100, ret_pct = 0, init_cred = 4;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit elig(int i);
        int ft, vc, eff;
        if (!req[i]) return 0;
        ft = int'(req_ft[i]);
        vc = int'(req_vc[i]);
        if (ft == FT_I || m_win == i) return 0;
        eff = cnt[vc] - ((m_win >= 0 && m_pend == vc) ? 1 : 0);
        if (eff <= 0) return 0;
        if (ft == FT_H) return !m_busy[vc];
        return m_busy[vc] && m_owner[vc] == i;
    endfunction

    // Advance the model across one clock edge using the inputs of the cycle
    task automatic model_step();
        int w, ow, op, ft, vc;
        w = -1;
        for (int k = 0; k < NI; k++)
            if (w < 0 && elig((m_rr + k) % NI)) w = (m_rr + k) % NI;
        ow = m_win;
        op = m_pend;
        if (w >= 0) begin
            ft = int'(req_ft[w]);
            vc = int'(req_vc[w]);
            m_win = w; m_sel = w; m_pend = vc; m_rr = (w + 1) % NI;
            if (ft == FT_H) begin m_busy[vc] = 1; m_owner[vc] = w; end
            else if (ft == FT_T) m_busy[vc] = 0;
        end else m_win = -1;
        if (ow >= 0) begin
            cnt[op]--; used[op]++;
            if (fq[ow].size() > 0) void'(fq[ow].pop_front());
        end
        for (int v = 0; v < NV; v++)
            if (used[v] > 0 && int'($urandom_range(99)) < ret_pct) begin
                used[v]--; cnt[v]++;
            end
    endtask

    task automatic push(int i, int ft, int vc);
        fq[i].push_back(ft * 16 + vc);
    endtask

    task automatic drive();
        int vc, nb;
        for (int i = 0; i < NI; i++) begin
            if (gen_en && fq[i].size() == 0 && $urandom_range(99) < 30) begin
                vc = int'($urandom_range(NV - 1));
                nb = int'($urandom_range(2));
                push(i, FT_H, vc);
                for (int b = 0; b < nb; b++) push(i, FT_B, vc);
                push(i, FT_T, vc);
            end
            if (fq[i].size() > 0 && int'($urandom_range(99)) < p_req) begin
                req[i] = 1'b1;
                req_ft[i] = 2'(fq[i][0] / 16);
                req_vc[i] = VB'(fq[i][0] % 16);
            end else begin
                req[i] = gen_en && ($urandom_range(99) < 10);
                req_ft[i] = 2'(FT_I);
                req_vc[i] = VB'($urandom_range(NV - 1));
            end
        end
        for (int v = 0; v < NV; v++) cred[v] = CW'(cnt[v]);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        drive();
    endtask

    // Reset asserted mid-cycle with requests still active
    task automatic do_reset();
        chk_en = 0;
        arst_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_ob_en", 64'(ob_en), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        m_win = -1; m_sel = 0; m_rr = 0; m_pend = 0;
        for (int v = 0; v < NV; v++) begin
            m_busy[v] = 0; m_owner[v] = 0; cnt[v] = init_cred; used[v] = 0;
        end
        for (int i = 0; i < NI; i++) fq[i].delete();
        req = '0; req_ft = '0; req_vc = '0;
        for (int v = 0; v < NV; v++) cred[v] = CW'(cnt[v]);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        #1;
        chk("rel_gnt", 64'(gnt), 64'(0));
        chk_en = 1;
        drive();
    endtask

    // Compare process: DUT registered outputs against the model every cycle
    initial begin
        logic [NI-1:0] eg;
        logic [NV-1:0] eb;
        logic [NV-1:0][SB-1:0] eo;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                eg = '0;
                if (m_win >= 0) eg[m_win] = 1'b1;
                for (int v = 0; v < NV; v++) begin
                    eb[v] = m_busy[v];
                    eo[v] = SB'(m_owner[v]);
                end
                chk("gnt", 64'(gnt), 64'(eg));
                chk("ob_en", 64'(ob_en), 64'(m_win >= 0));
                chk("sel", 64'(sel), 64'(m_sel));
                chk("vc_busy", 64'(busy), 64'(eb));
                chk("vc_owner", 64'(owner), 64'(eo));
            end
        end
    end

    initial begin
        int exp_sp [6] = '{0, -1, 0, -1, 0, -1};
        int exp_rr [8] = '{0, 3, 0, 3, 0, 3, 0, 3};
        int exp_cr [5] = '{1, -1, 1, -1, -1};
        int exp_ob [6] = '{1, -1, 1, -1, 1, 2};

        #1;
        // Single packet H,B,T on vc1 from in0, 4 credits
        init_cred = 4;
        do_reset();
        push(0, FT_H, 1); push(0, FT_B, 1); push(0, FT_T, 1);
        drive();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("sp_win", 64'(m_win), 64'(exp_sp[k]));
            if (k == 0) begin
                chk("sp_gnt_lit", 64'(gnt), 64'(5'b00001));
                chk("sp_busy_lit", 64'(busy[1]), 64'(1));
                chk("sp_owner_lit", 64'(owner[1]), 64'(0));
            end
            if (k == 1) chk("sp_gap_lit", 64'(ob_en), 64'(0));
            if (k == 4) chk("sp_free_lit", 64'(busy[1]), 64'(0));
        end
        chk("sp_cnt", 64'(cnt[1]), 64'(1));

        // Round-robin between in0 (vc0) and in3 (vc1)
        init_cred = 8;
        do_reset();
        push(0, FT_H, 0); push(0, FT_B, 0); push(0, FT_B, 0); push(0, FT_T, 0);
        push(3, FT_H, 1); push(3, FT_B, 1); push(3, FT_B, 1); push(3, FT_T, 1);
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_win", 64'(m_win), 64'(exp_rr[k]));
            if (k == 1) begin
                chk("rr_busy_lit", 64'(busy), 64'(4'b0011));
                chk("rr_own0_lit", 64'(owner[0]), 64'(0));
                chk("rr_own1_lit", 64'(owner[1]), 64'(3));
                chk("rr_gnt_lit", 64'(gnt), 64'(5'b01000));
            end
        end

        // Credit in flight on vc2 (2 credits), in1 then in4
        init_cred = 4;
        do_reset();
        cnt[2] = 2;
        push(1, FT_H, 2); push(1, FT_T, 2);
        push(4, FT_H, 2); push(4, FT_T, 2);
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("cr_win", 64'(m_win), 64'(exp_cr[k]));
        end
        chk("cr_cnt0", 64'(cnt[2]), 64'(0));
        chk("cr_blk_lit", 64'(gnt), 64'(0));
        cnt[2] = 1; used[2]--;
        drive();
        cycle();
        chk("cr_win_ret", 64'(m_win), 64'(4));
        chk("cr_gnt_lit", 64'(gnt), 64'(5'b10000));
        cycle();
        cycle();

        // Ownership block: in1 owns vc0, in2 head waits for the tail
        init_cred = 8;
        do_reset();
        push(1, FT_H, 0); push(1, FT_B, 0); push(1, FT_T, 0);
        push(2, FT_H, 0);
        drive();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("ob_win", 64'(m_win), 64'(exp_ob[k]));
        end
        chk("ob_owner_lit", 64'(owner[0]), 64'(2));
        chk("ob_busy_lit", 64'(busy[0]), 64'(1));

        // Randomized traffic, tight credits, reset mid-packet halfway
        init_cred = 2;
        do_reset();
        gen_en = 1; p_req = 75; ret_pct = 35;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if (c == 1500) do_reset();
        end

        // Randomized traffic, looser credits
        init_cred = 5;
        ret_pct = 60; p_req = 90;
        do_reset();
        for (int c = 0; c < 2000; c++) cycle();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
